fetch_queue: RTL

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue_pkg.sv | 24 ++
 rtl/fetch_queue_if.sv | 45 ++++
 rtl/fetch_fifo.sv | 74 +++++++
 rtl/fetch_queue.sv | 118 +++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue.
// The state encoding is fixed so that waveforms and debug tools decode it consistently.
package fetch_queue_pkg;

    localparam int unsigned WORD_W = 32;
    localparam logic [WORD_W-1:0] PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        StFetch   = 2'd0,
        StWait    = 2'd1,
        StDiscard = 2'd2
    } fq_state_e;

    typedef struct packed {
        logic [WORD_W-1:0] pc_plus4;
        logic [WORD_W-1:0] instr;
    } fq_entry_t;

    // Wraps modulo 2^32 by construction of the operand widths.
    function automatic logic [WORD_W-1:0] next_pc(input logic [WORD_W-1:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Memory-side and decode-side signals of the fetch queue, bundled for port connection.
// The master side is the fetch queue; the slave side is the memory plus the IF/ID stage.
interface fetch_queue_if;
    import fetch_queue_pkg::*;

    logic              imem_req_o;
    logic [WORD_W-1:0] imem_addr_o;
    logic              imem_rvalid_i;
    logic [WORD_W-1:0] imem_rdata_i;

    logic              redirect_i;
    logic [WORD_W-1:0] redirect_pc_i;

    logic              id_valid_o;
    logic              id_ready_i;
    logic [WORD_W-1:0] id_pc_plus4_o;
    logic [WORD_W-1:0] id_instr_o;

    modport master (
        output imem_req_o,
        output imem_addr_o,
        input  imem_rvalid_i,
        input  imem_rdata_i,
        input  redirect_i,
        input  redirect_pc_i,
        output id_valid_o,
        input  id_ready_i,
        output id_pc_plus4_o,
        output id_instr_o
    );

    modport slave (
        input  imem_req_o,
        input  imem_addr_o,
        output imem_rvalid_i,
        output imem_rdata_i,
        output redirect_i,
        output redirect_pc_i,
        input  id_valid_o,
        output id_ready_i,
        input  id_pc_plus4_o,
        input  id_instr_o
    );

endinterface

// File: rtl/fetch_fifo.sv
// Circular buffer of fetched {pc+4, instruction} entries with push, pop and flush.
// Head data is read straight from storage, so a pushed word appears one cycle later.
module fetch_fifo
    import fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  fq_entry_t              push_data_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    output fq_entry_t              head_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam logic [PtrW:0] FullCount = (PtrW + 1)'(DEPTH);

    fq_entry_t       mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [PtrW:0]   count_q;
    logic            do_push;
    logic            do_pop;

    // Flush wins over both push and pop; a full buffer still accepts a push alongside a pop.
    always_comb begin
        do_pop  = pop_i && (count_q != '0) && !flush_i;
        do_push = push_i && !flush_i && ((count_q != FullCount) || do_pop);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + (PtrW + 1)'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - (PtrW + 1)'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // An empty buffer presents zeros so the outputs match their reset values.
    assign head_o  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign count_o = count_q;

    count_bounded_a: assert property (@(posedge clk_i) disable iff (!rst_i)
        count_q <= FullCount);

    no_overflow_a: assert property (@(posedge clk_i) disable iff (!rst_i)
        (push_i && !flush_i && (count_q == FullCount)) |-> pop_i);

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: keeps one memory request in flight, buffers returned words
// for the IF/ID register, and flushes and refetches on a branch redirect.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int unsigned       DEPTH    = 4,
    parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk_i,
    input  logic          rst_i,
    fetch_queue_if.master bus
);

    localparam int unsigned CntW = $clog2(DEPTH) + 1;
    localparam logic [CntW-1:0] FullCount = CntW'(DEPTH);
    localparam logic [CntW-1:0] LastSlot  = CntW'(DEPTH - 1);

    fq_state_e         state_q;
    logic [WORD_W-1:0] pc_q;

    logic [CntW-1:0]   count;
    logic [CntW-1:0]   count_after_pop;
    fq_entry_t         head;
    fq_entry_t         push_entry;
    logic              redirect;
    logic              pop;
    logic              push;
    logic              issue;

    always_comb begin
        redirect        = bus.redirect_i;
        pop             = (count != '0) && bus.id_ready_i;
        count_after_pop = count - CntW'(pop);
        push            = 1'b0;
        issue           = 1'b0;
        case (state_q)
            StFetch: begin
                issue = !redirect && (count < FullCount);
            end
            StWait: begin
                if (bus.imem_rvalid_i && !redirect) begin
                    push  = 1'b1;
                    // Only chain the next request if its word is sure to find a free slot.
                    issue = count_after_pop < LastSlot;
                end
            end
            default: begin
            end
        endcase
        // Reset leaves the FSM in StFetch; keep the request low until reset is released.
        issue = issue && rst_i;
    end

    // While in StWait the fetch PC has already advanced past the outstanding request,
    // so it equals that request's pc+4.
    assign push_entry = '{pc_plus4: pc_q, instr: bus.imem_rdata_i};

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= StFetch;
            pc_q    <= RESET_PC;
        end else begin
            if (redirect) begin
                pc_q <= bus.redirect_pc_i;
            end else if (issue) begin
                pc_q <= next_pc(pc_q);
            end
            case (state_q)
                StFetch: begin
                    if (issue) begin
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    if (bus.imem_rvalid_i) begin
                        state_q <= issue ? StWait : StFetch;
                    end else if (redirect) begin
                        state_q <= StDiscard;
                    end
                end
                StDiscard: begin
                    if (bus.imem_rvalid_i) begin
                        state_q <= StFetch;
                    end
                end
                default: begin
                    state_q <= StFetch;
                end
            endcase
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .flush_i     (redirect),
        .head_o      (head),
        .count_o     (count)
    );

    assign bus.imem_req_o    = issue;
    assign bus.imem_addr_o   = pc_q;
    assign bus.id_valid_o    = (count != '0);
    assign bus.id_pc_plus4_o = head.pc_plus4;
    assign bus.id_instr_o    = head.instr;

    issue_state_a: assert property (@(posedge clk_i) disable iff (!rst_i)
        issue |-> (state_q == StFetch) || ((state_q == StWait) && bus.imem_rvalid_i));

    occupancy_a: assert property (@(posedge clk_i) disable iff (!rst_i)
        (state_q == StWait) |-> (count <= LastSlot) || bus.imem_rvalid_i || pop);

endmodule
